adc_serial_rx: RTL and testbench

Downstream consumer of the ADC clock divider.
- Uses the divided ADC serial clock and the slow channel-select toggle.
- Frames conversions on a serial ADC: drives chip-select low, shifts in MSB-first data on serial-clock rising edges, and presents a parallel sample with channel tag and one-cycle valid strobe.
- Feeds the flight-stabiliser filter/control logic.

---
 rtl/adc_pkg.sv | 30 +++
 rtl/sync_edge_det.sv | 28 ++
 rtl/adc_serial_rx.sv | 194 +++++++++++++++++++
 tb/tb_adc_serial_rx.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC receiver: FSM encoding, default
// frame geometry and a constant-width helper.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
  } adc_state_t;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_LEAD_BITS   = 4;
  localparam int DEF_GAP_EDGES   = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Ceiling log2; counter widths are sized as clog2(max_value + 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous clock-like input, with a third
// flop so a single-cycle rising-edge strobe can be produced in the clk domain.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign rise = sync_2 & ~prev;

endmodule

// File: rtl/adc_serial_rx.sv
// Serial ADC frame receiver: frames a conversion with cs_n, shifts in
// MSB-first data on sclk rises and presents a tagged parallel sample.
// Optional sclk-stall abort is built when ADC_SERIAL_RX_TIMEOUT_EN is defined.
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEAD_BITS = DEF_LEAD_BITS,
  parameter int GAP_EDGES = DEF_GAP_EDGES
`ifdef ADC_SERIAL_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              adc_sclk,
  input  logic              adc_chsel,
  input  logic              adc_dout,
  output logic              adc_cs_n,
  output logic              adc_ch,
  output logic [DATA_W-1:0] sample,
  output logic              sample_ch,
  output logic              sample_valid,
  output logic              busy,
  output logic              err
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_W;
  localparam int CNT_W      = clog2(FRAME_BITS + 1);
  localparam int GAP_W      = clog2(GAP_EDGES + 1);

  localparam logic [CNT_W-1:0] LEAD_CNT = CNT_W'(LEAD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EDGES - 1);

  adc_state_t        state;
  adc_state_t        state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_cnt_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] sample_nxt;
  logic              ch_q;
  logic              ch_nxt;
  logic              sample_ch_q;
  logic              sample_ch_nxt;

  logic              sclk_rise;
  logic              dout_sync_1;
  logic              dout_sync_2;

  sync_edge_det u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (adc_sclk),
    .rise (sclk_rise)
  );

  // Data gets the same two-flop latency as sclk, so the bit read in the
  // rise cycle is the one the ADC presented at that sclk edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_sync_1 <= 1'b0;
      dout_sync_2 <= 1'b0;
    end else begin
      dout_sync_1 <= adc_dout;
      dout_sync_2 <= dout_sync_1;
    end
  end

`ifdef ADC_SERIAL_RX_TIMEOUT_EN
  localparam int TMO_W = clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;
  logic             tmo_hit;

  // Counts clk cycles since the last sclk rise; only meaningful inside SHIFT.
  always_comb begin
    tmo_nxt = '0;
    if ((state == ST_SHIFT) && !sclk_rise) begin
      tmo_nxt = tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_nxt;
    end
  end

  assign tmo_hit = (state == ST_SHIFT) && (tmo_cnt == TMO_LIMIT);
  assign err     = tmo_hit;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    shift_nxt     = shift_reg;
    sample_nxt    = sample_q;
    ch_nxt        = ch_q;
    sample_ch_nxt = sample_ch_q;

    case (state)
      ST_IDLE: begin
        if (sclk_rise && en) begin
          ch_nxt      = adc_chsel;
          bit_cnt_nxt = '0;
          shift_nxt   = '0;
          state_nxt   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
`ifdef ADC_SERIAL_RX_TIMEOUT_EN
        if (tmo_hit) begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = '0;
        end else
`endif
        if (sclk_rise) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt >= LEAD_CNT) begin
            shift_nxt = {shift_reg[DATA_W-2:0], dout_sync_2};
          end
          // Capture on the final bit so sample and its strobe appear together.
          if (bit_cnt == LAST_BIT) begin
            sample_nxt    = {shift_reg[DATA_W-2:0], dout_sync_2};
            sample_ch_nxt = ch_q;
            state_nxt     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        gap_cnt_nxt = '0;
        state_nxt   = ST_GAP;
      end

      ST_GAP: begin
        if (sclk_rise) begin
          if (gap_cnt == GAP_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            gap_cnt_nxt = gap_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shift_reg   <= '0;
      sample_q    <= '0;
      ch_q        <= 1'b0;
      sample_ch_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      shift_reg   <= shift_nxt;
      sample_q    <= sample_nxt;
      ch_q        <= ch_nxt;
      sample_ch_q <= sample_ch_nxt;
    end
  end

  assign adc_cs_n     = (state != ST_SHIFT);
  assign busy         = (state == ST_SHIFT);
  assign sample_valid = (state == ST_DONE);
  assign adc_ch       = ch_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Randomised bench for adc_serial_rx against a rise-indexed frame model.
// Define ADC_SERIAL_RX_TIMEOUT_EN to also exercise the sclk-stall abort.
module tb_adc_serial_rx;

  localparam int DW   = 12;
  localparam int LEAD = 4;
  localparam int GAP  = 2;

  logic          clk;
  logic          rst;
  logic          en;
  logic          adc_sclk;
  logic          adc_chsel;
  logic          adc_dout;
  logic          adc_cs_n;
  logic          adc_ch;
  logic [DW-1:0] sample;
  logic          sample_ch;
  logic          sample_valid;
  logic          busy;
  logic          err;

  adc_serial_rx dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .adc_sclk     (adc_sclk),
    .adc_chsel    (adc_chsel),
    .adc_dout     (adc_dout),
    .adc_cs_n     (adc_cs_n),
    .adc_ch       (adc_ch),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Frame model indexed by sclk rise number: a frame starting at rise s
  // carries lead bits on s+1..s+LEAD and data MSB-first up to s+LEAD+DW.
  int            rise_n       = 0;
  bit            in_frame     = 1'b0;
  int            frame_start  = 0;
  int            next_allowed = 0;
  int            frames_done  = 0;
  logic [DW-1:0] cur_word     = '0;
  logic [DW-1:0] exp_sample   = '0;
  logic          exp_sample_ch = 1'b0;
  logic          exp_adc_ch   = 1'b0;
  logic [DW-1:0] data_q[$];

  int cyc            = 0;
  int dut_valid_cnt  = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      dut_valid_cnt  = dut_valid_cnt + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
  end

  task automatic model_reset();
    in_frame      = 1'b0;
    next_allowed  = 0;
    exp_sample    = '0;
    exp_sample_ch = 1'b0;
    exp_adc_ch    = 1'b0;
  endtask

  // One sclk period of 2*half clk; low phase first, rise at j == half.
  task automatic sclk_period(input int half);
    bit   ended;
    logic exp_valid;
    int   idx;
    ended = 1'b0;
    for (int j = 0; j < 2 * half; j++) begin
      @(negedge clk);
      exp_valid = ended && (j == half + 3);
      vectors++;
      if (sample_valid !== exp_valid) begin
        miscompares++;
        $display("[TB] FAIL sample_valid rise %0d j %0d: got %b expected %b", rise_n, j, sample_valid, exp_valid);
      end
      if (j < half || j >= half + 3) begin
        vectors++;
        if (adc_cs_n !== ~in_frame || busy !== in_frame) begin
          miscompares++;
          $display("[TB] FAIL cs_n/busy rise %0d: got %b/%b expected %b/%b", rise_n, adc_cs_n, busy, ~in_frame, in_frame);
        end
        vectors++;
        if (adc_ch !== exp_adc_ch) begin
          miscompares++;
          $display("[TB] FAIL adc_ch rise %0d: got %b expected %b", rise_n, adc_ch, exp_adc_ch);
        end
        vectors++;
        if (sample !== exp_sample || sample_ch !== exp_sample_ch) begin
          miscompares++;
          $display("[TB] FAIL sample rise %0d: got %h/%b expected %h/%b", rise_n, sample, sample_ch, exp_sample, exp_sample_ch);
        end
        vectors++;
        if (err !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL err rise %0d: got %b expected 0", rise_n, err);
        end
      end
      if (j == 0) begin
        adc_sclk = 1'b0;
        adc_dout = 1'($urandom);
        if (in_frame) begin
          idx = rise_n - frame_start - 1 - LEAD;
          if (idx >= 0 && idx < DW) adc_dout = cur_word[DW-1-idx];
        end
      end else if (j == half) begin
        adc_sclk = 1'b1;
        if (rst) begin
          if (!in_frame) begin
            if (en && rise_n >= next_allowed) begin
              in_frame    = 1'b1;
              frame_start = rise_n;
              exp_adc_ch  = adc_chsel;
              if (data_q.size() > 0) cur_word = data_q.pop_front();
              else cur_word = DW'($urandom);
            end
          end else if (rise_n == frame_start + LEAD + DW) begin
            in_frame      = 1'b0;
            ended         = 1'b1;
            exp_sample    = cur_word;
            exp_sample_ch = exp_adc_ch;
            next_allowed  = rise_n + GAP + 1;
            frames_done++;
          end
        end
        rise_n++;
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    adc_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    en = 1'b0;
    for (int p = 0; p < 40 && (in_frame || rise_n < next_allowed); p++) sclk_period(5);
    sclk_period(5);
    vectors++;
    if (dut_valid_cnt !== frames_done) begin
      miscompares++;
      $display("[TB] FAIL strobe_count: got %0d expected %0d", dut_valid_cnt, frames_done);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (adc_cs_n !== 1'b1 || sample !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 || adc_ch !== 1'b0 || sample_ch !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got cs_n=%b sample=%h valid=%b busy=%b ch=%b sch=%b err=%b expected 1 000 0 0 0 0 0",
               adc_cs_n, sample, sample_valid, busy, adc_ch, sample_ch, err);
    end
    en = 1'b1;
    for (int p = 0; p < 3; p++) sclk_period(5);
    en = 1'b0;
    release_reset();
    for (int p = 0; p < 4; p++) sclk_period(5);
  endtask

  task automatic test_single_frame();
    int base;
    base      = dut_valid_cnt;
    en        = 1'b1;
    adc_chsel = 1'b1;
    data_q.push_back(12'hA5C);
    for (int p = 0; p < 17; p++) sclk_period(50);
    vectors++;
    if (sample !== 12'hA5C || sample_ch !== 1'b1 || dut_valid_cnt - base !== 1) begin
      miscompares++;
      $display("[TB] FAIL single_frame: got %h ch %b strobes %0d expected a5c ch 1 strobes 1", sample, sample_ch, dut_valid_cnt - base);
    end
    drain();
  endtask

  task automatic test_channel_change();
    en        = 1'b1;
    adc_chsel = 1'b0;
    for (int p = 0; p < 6; p++) sclk_period(6);
    adc_chsel = 1'b1;
    for (int p = 0; p < 11; p++) sclk_period(6);
    vectors++;
    if (sample_ch !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL chsel_mid_frame: got %b expected 0", sample_ch);
    end
    for (int p = 0; p < 19; p++) sclk_period(6);
    vectors++;
    if (sample_ch !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL chsel_next_frame: got %b expected 1", sample_ch);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int base;
    base = dut_valid_cnt;
    en   = 1'b1;
    data_q.push_back(12'hFFF);
    data_q.push_back(12'h001);
    for (int p = 0; p < 17; p++) sclk_period(10);
    vectors++;
    if (sample !== 12'hFFF) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %h expected fff", sample);
    end
    for (int p = 0; p < 19; p++) sclk_period(10);
    vectors++;
    if (sample !== 12'h001 || dut_valid_cnt - base !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %h strobes %0d expected 001 strobes 2", sample, dut_valid_cnt - base);
    end
    vectors++;
    if (last_valid_cyc - prev_valid_cyc !== 19 * 20) begin
      miscompares++;
      $display("[TB] FAIL b2b_spacing: got %0d clk expected %0d", last_valid_cyc - prev_valid_cyc, 19 * 20);
    end
    drain();
  endtask

  task automatic test_en_fall();
    int base;
    base = dut_valid_cnt;
    en   = 1'b1;
    for (int p = 0; p < 5; p++) sclk_period(5);
    en = 1'b0;
    for (int p = 0; p < 12; p++) sclk_period(5);
    vectors++;
    if (dut_valid_cnt - base !== 1) begin
      miscompares++;
      $display("[TB] FAIL en_fall_complete: got %0d strobes expected 1", dut_valid_cnt - base);
    end
    for (int p = 0; p < 25; p++) sclk_period(5);
    vectors++;
    if (dut_valid_cnt - base !== 1 || adc_cs_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL en_fall_idle: got %0d strobes cs_n %b expected 1 strobes cs_n 1", dut_valid_cnt - base, adc_cs_n);
    end
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int base;
    en = 1'b1;
    for (int p = 0; p < 9; p++) sclk_period(5);
    base = dut_valid_cnt;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (adc_cs_n !== 1'b1 || busy !== 1'b0 || sample !== '0 || sample_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_frame: got cs_n %b busy %b sample %h valid %b expected 1 0 000 0", adc_cs_n, busy, sample, sample_valid);
    end
    model_reset();
    for (int p = 0; p < 2; p++) sclk_period(5);
    release_reset();
    vectors++;
    if (dut_valid_cnt !== base) begin
      miscompares++;
      $display("[TB] FAIL reset_no_strobe: got %0d strobes expected %0d", dut_valid_cnt, base);
    end
    data_q.push_back(12'h3C7);
    for (int p = 0; p < 17; p++) sclk_period(5);
    vectors++;
    if (sample !== 12'h3C7) begin
      miscompares++;
      $display("[TB] FAIL reset_recover: got %h expected 3c7", sample);
    end
    drain();
  endtask

  task automatic test_random();
    for (int p = 0; p < 300; p++) begin
      if ($urandom_range(7) == 0) en = ~en;
      if ($urandom_range(3) == 0) adc_chsel = ~adc_chsel;
      if ($urandom_range(9) == 0) data_q.push_back(DW'($urandom));
      sclk_period($urandom_range(9, 4));
    end
    drain();
    data_q.delete();
  endtask

`ifdef ADC_SERIAL_RX_TIMEOUT_EN
  task automatic test_timeout();
    int   base;
    logic exp_err;
    logic exp_cs;
    base = dut_valid_cnt;
    en   = 1'b1;
    for (int p = 0; p < 7; p++) sclk_period(5);
    en = 1'b0;
    // Counter clears at the end of the rise cycle, so err lands 1025 clk later.
    for (int k = 5; k <= 1040; k++) begin
      @(negedge clk);
      exp_err = (k == 1027);
      exp_cs  = (k >= 1028);
      vectors++;
      if (err !== exp_err || adc_cs_n !== exp_cs || sample_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL timeout k %0d: got err %b cs_n %b valid %b expected %b %b 0", k, err, adc_cs_n, sample_valid, exp_err, exp_cs);
      end
    end
    in_frame     = 1'b0;
    next_allowed = rise_n + GAP;
    vectors++;
    if (dut_valid_cnt !== base) begin
      miscompares++;
      $display("[TB] FAIL timeout_no_strobe: got %0d expected %0d", dut_valid_cnt, base);
    end
    en = 1'b1;
    data_q.push_back(12'h5A3);
    for (int p = 0; p < GAP + 17; p++) sclk_period(5);
    vectors++;
    if (sample !== 12'h5A3) begin
      miscompares++;
      $display("[TB] FAIL timeout_resume: got %h expected 5a3", sample);
    end
    drain();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    adc_sclk  = 1'b0;
    adc_chsel = 1'b0;
    adc_dout  = 1'b0;
    #5;
    rst = 1'b0;
    test_reset();
    test_single_frame();
    test_channel_change();
    test_back_to_back();
    test_en_fall();
    test_reset_mid_frame();
    test_random();
`ifdef ADC_SERIAL_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
